// File: rtl/param_down_counter_if.sv
// Load handshake bundle for param_down_counter; load_value width follows MAX_COUNT.
interface param_down_counter_if #(
  parameter int MAX_COUNT = 255
);
  localparam int W = $clog2(MAX_COUNT + 1);

  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] load_value;

  modport master (output load_valid, output load_value, input load_ready);
  modport slave  (input load_valid, input load_value, output load_ready);
endinterface

// File: rtl/param_down_counter.sv
// Loadable countdown timer with valid/ready load and one-cycle done pulse at terminal count.
// Define PARAM_DOWN_COUNTER_AUTO_RELOAD_EN for periodic reload from a captured start value.
module param_down_counter #(
  parameter int MAX_COUNT = 255
) (
  input  logic                             clk,
  input  logic                             rst_n,
  param_down_counter_if.slave              load_if,
  input  logic                             en_i,
  input  logic                             abort_i,
  output logic [$clog2(MAX_COUNT+1)-1:0]   count_o,
  output logic                             busy_o,
  output logic                             done_o
);
  localparam int             W       = $clog2(MAX_COUNT + 1);
  localparam logic [W:0]     MAX_EXT = (W+1)'(MAX_COUNT);
  localparam logic [W-1:0]   MAX_W   = W'(MAX_COUNT);

  typedef enum logic {IDLE, RUN} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic           done_q, done_d;
  logic [W-1:0]   load_sat;
  logic           load_fire;

  // Compare one bit wider so MAX_COUNT values that fill W bits never saturate spuriously.
  assign load_sat  = ({1'b0, load_if.load_value} > MAX_EXT) ? MAX_W : load_if.load_value;

`ifdef PARAM_DOWN_COUNTER_AUTO_RELOAD_EN
  logic [W-1:0]   reload_q, reload_d;
  assign load_if.load_ready = 1'b1;
`else
  assign load_if.load_ready = (state_q == IDLE);
`endif

  assign load_fire = load_if.load_valid & load_if.load_ready & ~abort_i;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
`ifdef PARAM_DOWN_COUNTER_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (abort_i) begin
      state_d = IDLE;
      count_d = '0;
`ifdef PARAM_DOWN_COUNTER_AUTO_RELOAD_EN
      reload_d = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (load_fire) begin
            count_d = load_sat;
`ifdef PARAM_DOWN_COUNTER_AUTO_RELOAD_EN
            reload_d = load_sat;
`endif
            if (load_sat == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
`ifdef PARAM_DOWN_COUNTER_AUTO_RELOAD_EN
          if (load_fire) begin
            reload_d = load_sat;
          end
`endif
          if (en_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
            if (count_q == W'(1)) begin
              done_d = 1'b1;
`ifdef PARAM_DOWN_COUNTER_AUTO_RELOAD_EN
              // A load coinciding with expiry already governs the next period.
              if (reload_d != '0) begin
                count_d = reload_d;
              end else begin
                state_d = IDLE;
              end
`else
              state_d = IDLE;
`endif
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

`ifdef PARAM_DOWN_COUNTER_AUTO_RELOAD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reload_q <= '0;
    end else begin
      reload_q <= reload_d;
    end
  end
`endif

  assign count_o = count_q;
  assign busy_o  = (state_q == RUN);
  assign done_o  = done_q;
endmodule

// File: tb/tb_param_down_counter.sv
// Directed, table-driven bench for param_down_counter (one-shot or auto-reload build)
// plus a small MAX_COUNT instance for load saturation.
module tb_param_down_counter;
  localparam int MAX_COUNT = 255;
  localparam int W         = $clog2(MAX_COUNT + 1);
  localparam int SMALL_MAX = 10;
  localparam int SW        = $clog2(SMALL_MAX + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          abort;
  logic [W-1:0]  count;
  logic          busy;
  logic          done;

  logic          smallEn;
  logic          smallAbort;
  logic [SW-1:0] smallCount;
  logic          smallBusy;
  logic          smallDone;

  int errors = 0;
  int checks = 0;

  param_down_counter_if #(.MAX_COUNT(MAX_COUNT)) loadIf ();
  param_down_counter_if #(.MAX_COUNT(SMALL_MAX)) smallIf ();

  param_down_counter #(.MAX_COUNT(MAX_COUNT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_if (loadIf),
    .en_i    (en),
    .abort_i (abort),
    .count_o (count),
    .busy_o  (busy),
    .done_o  (done)
  );

  param_down_counter #(.MAX_COUNT(SMALL_MAX)) dutSmall (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_if (smallIf),
    .en_i    (smallEn),
    .abort_i (smallAbort),
    .count_o (smallCount),
    .busy_o  (smallBusy),
    .done_o  (smallDone)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic  lv;
    int    val;
    logic  en;
    logic  ab;
    int    expCount;
    logic  expBusy;
    logic  expDone;
    logic  expReady;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic lv, int v, logic e, logic a,
                              int c, logic b, logic d, logic r);
    vec_t t;
    t.name = n; t.lv = lv; t.val = v; t.en = e; t.ab = a;
    t.expCount = c; t.expBusy = b; t.expDone = d; t.expReady = r;
    return t;
  endfunction

  task automatic checkValue(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput(string name, int expCount, logic expBusy, logic expDone, logic expReady);
    checkValue({name, ".count"}, int'(count), expCount);
    checkValue({name, ".busy"}, int'(busy), int'(expBusy));
    checkValue({name, ".done"}, int'(done), int'(expDone));
    checkValue({name, ".ready"}, int'(loadIf.load_ready), int'(expReady));
  endtask

  // Drive one cycle of inputs, then sample 1ns after the rising edge.
  task automatic applyStimulus(logic lv, int val, logic e, logic a);
    loadIf.load_valid = lv;
    loadIf.load_value = val[W-1:0];
    en                = e;
    abort             = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    loadIf.load_valid = 1'b0;
    loadIf.load_value = '0;
    en = 1'b0;
    abort = 1'b0;
    smallIf.load_valid = 1'b0;
    smallIf.load_value = '0;
    smallEn = 1'b0;
    smallAbort = 1'b0;

    #12;
    checkOutput("reset_state", 0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

`ifndef PARAM_DOWN_COUNTER_AUTO_RELOAD_EN
    vecs.push_back(mk("basic_load5",  1, 5,   0, 0, 5,   1, 0, 0));
    vecs.push_back(mk("basic_4",      0, 0,   1, 0, 4,   1, 0, 0));
    vecs.push_back(mk("basic_3",      0, 0,   1, 0, 3,   1, 0, 0));
    vecs.push_back(mk("basic_2",      0, 0,   1, 0, 2,   1, 0, 0));
    vecs.push_back(mk("basic_1",      0, 0,   1, 0, 1,   1, 0, 0));
    vecs.push_back(mk("basic_done",   0, 0,   1, 0, 0,   0, 1, 1));
    vecs.push_back(mk("basic_after",  0, 0,   1, 0, 0,   0, 0, 1));
    vecs.push_back(mk("gate_load3",   1, 3,   0, 0, 3,   1, 0, 0));
    vecs.push_back(mk("gate_en1",     0, 0,   1, 0, 2,   1, 0, 0));
    vecs.push_back(mk("gate_en0a",    0, 0,   0, 0, 2,   1, 0, 0));
    vecs.push_back(mk("gate_en0b",    0, 0,   0, 0, 2,   1, 0, 0));
    vecs.push_back(mk("gate_en1b",    0, 0,   1, 0, 1,   1, 0, 0));
    vecs.push_back(mk("gate_done",    0, 0,   1, 0, 0,   0, 1, 1));
    vecs.push_back(mk("gate_idle",    0, 0,   1, 0, 0,   0, 0, 1));
    vecs.push_back(mk("zero_load",    1, 0,   1, 0, 0,   0, 1, 1));
    vecs.push_back(mk("zero_after",   0, 0,   1, 0, 0,   0, 0, 1));
    vecs.push_back(mk("run_load4",    1, 4,   0, 0, 4,   1, 0, 0));
    vecs.push_back(mk("run_reject1",  1, 9,   1, 0, 3,   1, 0, 0));
    vecs.push_back(mk("run_reject2",  1, 9,   1, 0, 2,   1, 0, 0));
    vecs.push_back(mk("run_to1",      0, 0,   1, 0, 1,   1, 0, 0));
    vecs.push_back(mk("abort_at1",    0, 0,   1, 1, 0,   0, 0, 1));
    vecs.push_back(mk("abort_idle",   0, 0,   1, 0, 0,   0, 0, 1));
    vecs.push_back(mk("abort_load",   1, 6,   0, 1, 0,   0, 0, 1));
    vecs.push_back(mk("abort_load_n", 0, 0,   1, 0, 0,   0, 0, 1));
    vecs.push_back(mk("max_load",     1, 255, 0, 0, 255, 1, 0, 0));
    vecs.push_back(mk("max_dec",      0, 0,   1, 0, 254, 1, 0, 0));
    vecs.push_back(mk("max_abort",    0, 0,   1, 1, 0,   0, 0, 1));
`else
    vecs.push_back(mk("ar_load4",     1, 4,   1, 0, 4,   1, 0, 1));
    vecs.push_back(mk("ar_3",         0, 0,   1, 0, 3,   1, 0, 1));
    vecs.push_back(mk("ar_2",         0, 0,   1, 0, 2,   1, 0, 1));
    vecs.push_back(mk("ar_1",         0, 0,   1, 0, 1,   1, 0, 1));
    vecs.push_back(mk("ar_reload4",   0, 0,   1, 0, 4,   1, 1, 1));
    vecs.push_back(mk("ar_3b",        0, 0,   1, 0, 3,   1, 0, 1));
    vecs.push_back(mk("ar_load2",     1, 2,   1, 0, 2,   1, 0, 1));
    vecs.push_back(mk("ar_1b",        0, 0,   1, 0, 1,   1, 0, 1));
    vecs.push_back(mk("ar_reload2",   0, 0,   1, 0, 2,   1, 1, 1));
    vecs.push_back(mk("ar_1c",        0, 0,   1, 0, 1,   1, 0, 1));
    vecs.push_back(mk("ar_reload2b",  0, 0,   1, 0, 2,   1, 1, 1));
    vecs.push_back(mk("ar_abort",     0, 0,   1, 1, 0,   0, 0, 1));
    vecs.push_back(mk("ar_idle",      0, 0,   1, 0, 0,   0, 0, 1));
`endif

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].lv, vecs[i].val, vecs[i].en, vecs[i].ab);
      checkOutput(vecs[i].name, vecs[i].expCount, vecs[i].expBusy, vecs[i].expDone, vecs[i].expReady);
    end

    // Saturation on a small instance: 13 exceeds MAX_COUNT=10.
    smallIf.load_valid = 1'b1;
    smallIf.load_value = 4'd13;
    applyStimulus(0, 0, 0, 0);
    checkValue("sat_count", int'(smallCount), SMALL_MAX);
    checkValue("sat_busy", int'(smallBusy), 1);
    smallIf.load_valid = 1'b0;
    smallAbort = 1'b1;
    applyStimulus(0, 0, 0, 0);
    checkValue("sat_abort_count", int'(smallCount), 0);
    checkValue("sat_abort_busy", int'(smallBusy), 0);
    checkValue("sat_abort_done", int'(smallDone), 0);
    smallAbort = 1'b0;
    smallIf.load_valid = 1'b1;
    smallIf.load_value = 4'd7;
    applyStimulus(0, 0, 0, 0);
    checkValue("nosat_count", int'(smallCount), 7);
    smallIf.load_valid = 1'b0;

    // Reset mid-run at count 7: async clear, then no late done after release.
    applyStimulus(1, 10, 0, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 1, 0);
    end
    checkValue("prerst_count", int'(count), 7);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async", 0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(0, 0, 1, 0);
      checkValue("postrst_done", int'(done), 0);
      checkValue("postrst_count", int'(count), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
